// File: rtl/mul16_pkg.sv
// ============================================================================
// Module : mul16_pkg
// Brief  : Shared FSM encodings, operand width and clog2 helper for the
//          mul16 share arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul16_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MUL16_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/Multiplier16bit.sv
// ============================================================================
// Module : Multiplier16bit
// Brief  : Combinational unsigned 16x16 -> 32 multiplier datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module Multiplier16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  assign o_p = {16'd0, i_a} * {16'd0, i_b};

endmodule

`default_nettype wire

// File: rtl/mul16_grant_pick.sv
// ============================================================================
// Module : mul16_grant_pick
// Brief  : Combinational grant selector: valid vector + start pointer ->
//          one-hot grant and index. Round-robin when MUL16_ARB_RR_EN is
//          defined, otherwise lowest-index fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul16_grant_pick
  import mul16_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDW-1:0]   i_start,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

`ifdef MUL16_ARB_RR_EN
  int w_k;

  // Walk the ring starting at the pointer; the first valid requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = (int'(i_start) + i) % N_REQ;
      if (!o_any && i_valid[w_k]) begin
        o_any      = 1'b1;
        o_idx      = IDW'(w_k);
        o_grant[w_k] = 1'b1;
      end
    end
  end
`else
  logic w_unused_start;
  assign w_unused_start = ^i_start;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_any && i_valid[i]) begin
        o_any      = 1'b1;
        o_idx      = IDW'(i);
        o_grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mul16_share_arbiter.sv
// ============================================================================
// Module : mul16_share_arbiter
// Brief  : Shares one 16x16 multiplier among N_REQ requesters, one operation
//          outstanding at a time. Macro MUL16_ARB_RR_EN selects round-robin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul16_share_arbiter
  import mul16_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int W       = MUL16_W,
  parameter  int MUL_LAT = 1,
  localparam int IDW     = clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*W-1:0]     rsp_data
);

  localparam int LCW = (MUL_LAT > 1) ? clog2(MUL_LAT) : 1;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [W-1:0]     r_opx;
  logic [W-1:0]     r_opy;
  logic [IDW-1:0]   r_id;
  logic [LCW-1:0]   r_lat_cnt;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [2*W-1:0]   r_rsp_data;
  logic [2*W-1:0]   w_mul_out;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_any;
  logic [IDW-1:0]   w_start;
  logic             w_hs;

`ifdef MUL16_ARB_RR_EN
  logic [IDW-1:0] r_rr_ptr;
  assign w_start = r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_gidx == IDW'(N_REQ - 1)) ? '0 : w_gidx + IDW'(1);
    end
  end
`else
  assign w_start = '0;
`endif

  mul16_grant_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_valid (req_valid),
    .i_start (w_start),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  generate
    if (W == MUL16_W) begin : g_mul16
      Multiplier16bit u_mul (
        .i_a (r_opx),
        .i_b (r_opy),
        .o_p (w_mul_out)
      );
    end else begin : g_mul_generic
      assign w_mul_out = {{W{1'b0}}, r_opx} * {{W{1'b0}}, r_opy};
    end
  endgenerate

  // Reset blocks the grant so nothing is accepted in the reset cycle.
  assign w_hs = (r_state == ST_IDLE) && w_any && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_next_state = ST_BUSY;
      ST_BUSY: if (r_lat_cnt == '0) w_next_state = ST_DONE;
      ST_DONE: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && !rst) req_ready = w_grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opx       <= '0;
      r_opy       <= '0;
      r_id        <= '0;
      r_lat_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_opx     <= req_x[w_gidx*W +: W];
            r_opy     <= req_y[w_gidx*W +: W];
            r_id      <= w_gidx;
            r_lat_cnt <= LCW'(MUL_LAT - 1);
          end
        end
        ST_BUSY: begin
          if (r_lat_cnt == '0) begin
            r_rsp_data  <= w_mul_out;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - LCW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_mul16_share_arbiter.sv
// ============================================================================
// Module : tb_mul16_share_arbiter
// Brief  : Directed self-checking bench for mul16_share_arbiter (N_REQ=4,
//          W=16, MUL_LAT=1); honours MUL16_ARB_RR_EN for expected grant order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul16_share_arbiter;

  localparam int LAT = 1;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  mul16_share_arbiter #(
    .N_REQ   (4),
    .W       (16),
    .MUL_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp);
    int n;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_x[id*16 +: 16] = x;
    req_y[id*16 +: 16] = y;
    @(negedge clk);
    check("grant_onehot", 64'(req_ready), 64'(4'b0001 << id));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    check("latency", 64'(n), 64'(LAT));
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("rsp_data", 64'(rsp_data), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int exp_id;
    logic [15:0] rx;
    logic [15:0] ry;
    int rid;

    rst       = 1'b1;
    req_valid = 4'hF;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests present that must not be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;

    issue(0, 16'd3, 16'd5, 32'd15);
    issue(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    issue(2, 16'h0000, 16'hABCD, 32'h0);
    issue(3, 16'h8000, 16'h0002, 32'h00010000);

    // All four requesters continuously valid, y=1, x=id+1.
    pulse_rst();
    for (int k = 0; k < 4; k++) begin
      req_x[k*16 +: 16] = 16'(k + 1);
      req_y[k*16 +: 16] = 16'd1;
    end
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
`ifdef MUL16_ARB_RR_EN
      exp_id = i % 4;
`else
      exp_id = 0;
`endif
      wait_rsp(n);
      check("arb_order_id", 64'(rsp_id), 64'(exp_id));
      check("arb_order_data", 64'(rsp_data), 64'(exp_id + 1));
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;

    // Backpressure in DONE for 10 cycles while another requester waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_x[32 +: 16] = 16'h1234;
    req_y[32 +: 16] = 16'h0010;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_x[16 +: 16] = 16'd7;
    req_y[16 +: 16] = 16'd6;
    wait_rsp(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'd2);
      check("hold_data", 64'(rsp_data), 64'h12340);
      check("hold_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after_release_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    check("after_release_id", 64'(rsp_id), 64'd1);
    check("after_release_data", 64'(rsp_data), 64'd42);
    @(posedge clk); #1;

    // Reset while BUSY discards the operation; next grant goes to requester 0.
    req_valid = 4'b1000;
    req_x[48 +: 16] = 16'd9;
    req_y[48 +: 16] = 16'd9;
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_x[0 +: 16] = 16'd5;
    req_y[0 +: 16] = 16'd7;
    @(negedge clk);
    check("busy_rst_no_grant", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("busy_rst_no_rsp", 64'(rsp_valid), 64'd0);
    check("busy_rst_next_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    check("busy_rst_latency", 64'(n), 64'(LAT));
    check("busy_rst_id", 64'(rsp_id), 64'd0);
    check("busy_rst_data", 64'(rsp_data), 64'd35);
    @(posedge clk); #1;

    // Random operands against the bench's own product.
    for (int i = 0; i < 10000; i++) begin
      rid = int'($urandom_range(0, 3));
      rx  = 16'($urandom);
      ry  = 16'($urandom);
      issue(rid, rx, ry, {16'd0, rx} * {16'd0, ry});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
